// File: rtl/kros_pkg.sv
// Shared types and constants for the KROS LED sequencer: pattern enum,
// 7-segment codes and pattern entry values.
package kros_pkg;

  localparam int LED_W = 10;

  typedef enum logic [1:0] {
    SEQ_BOUNCE,
    SEQ_CHASE,
    SEQ_COUNT,
    SEQ_ALT
  } seq_e;

  localparam logic [6:0] SEG_D0    = 7'h40;
  localparam logic [6:0] SEG_D1    = 7'h79;
  localparam logic [6:0] SEG_D2    = 7'h24;
  localparam logic [6:0] SEG_D3    = 7'h30;
  localparam logic [6:0] SEG_D4    = 7'h19;
  localparam logic [6:0] SEG_D5    = 7'h12;
  localparam logic [6:0] SEG_D6    = 7'h02;
  localparam logic [6:0] SEG_D7    = 7'h78;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [LED_W-1:0] ENTRY_BOUNCE = 10'h001;
  localparam logic [LED_W-1:0] ENTRY_CHASE  = 10'h001;
  localparam logic [LED_W-1:0] ENTRY_COUNT  = 10'h000;
  localparam logic [LED_W-1:0] ENTRY_ALT    = 10'h155;
  localparam logic [LED_W-1:0] ALT_OTHER    = 10'h2AA;

  function automatic logic [6:0] seg_digit(input logic [2:0] d);
    case (d)
      3'd0:    return SEG_D0;
      3'd1:    return SEG_D1;
      3'd2:    return SEG_D2;
      3'd3:    return SEG_D3;
      3'd4:    return SEG_D4;
      3'd5:    return SEG_D5;
      3'd6:    return SEG_D6;
      default: return SEG_D7;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] entry_value(input seq_e s);
    case (s)
      SEQ_BOUNCE: return ENTRY_BOUNCE;
      SEQ_CHASE:  return ENTRY_CHASE;
      SEQ_COUNT:  return ENTRY_COUNT;
      default:    return ENTRY_ALT;
    endcase
  endfunction

endpackage

// File: rtl/kros_button.sv
// Active-low pushbutton conditioner: 3-flop synchronizer and one-pulse press.
// With KROS_DEBOUNCE_EN defined, a press needs DEBOUNCE_CYCLES stable-low cycles.
module kros_button
`ifdef KROS_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYCLES = 16)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic press
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= pb;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef KROS_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Counter saturates at DEBOUNCE_CYCLES so a long hold pulses only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (s2) begin
      cnt <= '0;
    end else if (cnt != CW'(DEBOUNCE_CYCLES)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign press = ~s2 & (cnt == CW'(DEBOUNCE_CYCLES - 1));
`else
  assign press = s3 & ~s2;
`endif

endmodule

// File: rtl/kros_sim_only.sv
// KROS LED sequencer, simulation build: slow_clk is an input sampled as data.
// Optional button debounce is enabled with `define KROS_DEBOUNCE_EN.
module kros_sim_only
  import kros_pkg::*;
#(
  parameter int FREQ_RESET = 4
`ifdef KROS_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic             CLK_50,
  input  logic             reset,
  input  logic             pb_freq_up,
  input  logic             pb_freq_dn,
  input  logic             pb_seq_up,
  input  logic             pb_seq_dn,
  input  logic             slow_clk,
  output logic [LED_W-1:0] LEDR,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5
);

  logic [3:0] pb_raw;
  logic [3:0] press;
  logic       freq_up, freq_dn, seq_up, seq_dn;

  assign pb_raw = {pb_freq_up, pb_freq_dn, pb_seq_up, pb_seq_dn};
  assign {freq_up, freq_dn, seq_up, seq_dn} = press;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    kros_button
`ifdef KROS_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_btn (
      .clk   (CLK_50),
      .rst   (reset),
      .pb    (pb_raw[i]),
      .press (press[i])
    );
  end

  logic sc1, sc2, sc3, tick;

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      sc1 <= 1'b0;
      sc2 <= 1'b0;
      sc3 <= 1'b0;
    end else begin
      sc1 <= slow_clk;
      sc2 <= sc1;
      sc3 <= sc2;
    end
  end

  assign tick = sc2 & ~sc3;

  seq_e       seq, seq_next;
  logic [2:0] level, tick_cnt;
  logic [3:0] pos, pos_next;
  logic       dir_up, dir_next, step;

  always_comb begin
    seq_next = seq;
    if (seq_up & ~seq_dn)
      seq_next = seq_e'(seq + 2'd1);
    else if (seq_dn & ~seq_up)
      seq_next = seq_e'(seq - 2'd1);
  end

  always_comb begin
    pos_next = pos;
    dir_next = dir_up;
    if (dir_up) begin
      if (pos == 4'd9) begin
        pos_next = 4'd8;
        dir_next = 1'b0;
      end else begin
        pos_next = pos + 4'd1;
      end
    end else begin
      if (pos == 4'd0) begin
        pos_next = 4'd1;
        dir_next = 1'b1;
      end else begin
        pos_next = pos - 4'd1;
      end
    end
  end

  // ">=" so a level raised below the current count steps on the next tick.
  assign step = tick & (tick_cnt >= (3'd7 - level));

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      level <= 3'(FREQ_RESET);
    end else if (freq_up & ~freq_dn & (level != 3'd7)) begin
      level <= level + 3'd1;
    end else if (freq_dn & ~freq_up & (level != 3'd0)) begin
      level <= level - 3'd1;
    end
  end

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      seq      <= SEQ_BOUNCE;
      tick_cnt <= 3'd0;
      pos      <= 4'd0;
      dir_up   <= 1'b1;
      LEDR     <= ENTRY_BOUNCE;
    end else if (seq_next != seq) begin
      seq      <= seq_next;
      LEDR     <= entry_value(seq_next);
      tick_cnt <= 3'd0;
      pos      <= 4'd0;
      dir_up   <= 1'b1;
    end else if (step) begin
      tick_cnt <= 3'd0;
      case (seq)
        SEQ_BOUNCE: begin
          pos    <= pos_next;
          dir_up <= dir_next;
          LEDR   <= LED_W'(1) << pos_next;
        end
        SEQ_CHASE: LEDR <= {LEDR[LED_W-2:0], LEDR[LED_W-1]};
        SEQ_COUNT: LEDR <= LEDR + 1'b1;
        default:   LEDR <= (LEDR == ENTRY_ALT) ? ALT_OTHER : ENTRY_ALT;
      endcase
    end else if (tick) begin
      tick_cnt <= tick_cnt + 3'd1;
    end
  end

  assign HEX0 = seg_digit(level);
  assign HEX1 = SEG_F;
  assign HEX2 = SEG_BLANK;
  assign HEX3 = seg_digit(seq);
  assign HEX4 = SEG_S;
  assign HEX5 = SEG_BLANK;

endmodule

// File: tb/tb_kros_sim_only.sv
// Directed self-checking bench for kros_sim_only: the bench drives slow_clk
// itself so every step lands on a known tick count.
module tb_kros_sim_only;

  logic       CLK_50 = 1'b0;
  logic       reset;
  logic       pb_freq_up, pb_freq_dn, pb_seq_up, pb_seq_dn;
  logic       slow_clk;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int checks   = 0;
  int failures = 0;

  kros_sim_only dut (
    .CLK_50     (CLK_50),
    .reset      (reset),
    .pb_freq_up (pb_freq_up),
    .pb_freq_dn (pb_freq_dn),
    .pb_seq_up  (pb_seq_up),
    .pb_seq_dn  (pb_seq_dn),
    .slow_clk   (slow_clk),
    .LEDR       (LEDR),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX5       (HEX5)
  );

  always #10 CLK_50 = ~CLK_50;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK_50);
  endtask

  task automatic give_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      slow_clk = 1'b1;
      wait_cycles(5);
      slow_clk = 1'b0;
      wait_cycles(5);
    end
  endtask

  // mask bits: {freq_up, freq_dn, seq_up, seq_dn}; held low 50 cycles (1000 ns)
  task automatic apply_stimulus(input logic [3:0] mask, input int times);
    for (int i = 0; i < times; i++) begin
      {pb_freq_up, pb_freq_dn, pb_seq_up, pb_seq_dn} = ~mask;
      wait_cycles(50);
      {pb_freq_up, pb_freq_dn, pb_seq_up, pb_seq_dn} = 4'b1111;
      wait_cycles(6);
    end
  endtask

  task automatic check_output(input string tag, input logic [9:0] observed,
                              input logic [9:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    {pb_freq_up, pb_freq_dn, pb_seq_up, pb_seq_dn} = 4'b1111;
    slow_clk = 1'b0;
    wait_cycles(20);
    reset = 1'b0;
    wait_cycles(2);

    check_output("reset_ledr", LEDR, 10'h001);
    check_output("reset_hex3", {3'b0, HEX3}, 10'h040);
    check_output("reset_hex0", {3'b0, HEX0}, 10'h019);
    check_output("hex1_F",     {3'b0, HEX1}, 10'h00E);
    check_output("hex2_blank", {3'b0, HEX2}, 10'h07F);
    check_output("hex4_S",     {3'b0, HEX4}, 10'h012);
    check_output("hex5_blank", {3'b0, HEX5}, 10'h07F);

    give_ticks(3);
    check_output("bounce_3ticks", LEDR, 10'h001);
    give_ticks(1);
    check_output("bounce_4ticks", LEDR, 10'h002);
    give_ticks(4);
    check_output("bounce_8ticks", LEDR, 10'h004);

    apply_stimulus(4'b0010, 1);
    check_output("chase_hex3",  {3'b0, HEX3}, 10'h079);
    check_output("chase_entry", LEDR, 10'h001);
    give_ticks(4);
    check_output("chase_step1", LEDR, 10'h002);
    give_ticks(32);
    check_output("chase_step9", LEDR, 10'h200);
    give_ticks(4);
    check_output("chase_wrap10", LEDR, 10'h001);
    give_ticks(120);
    check_output("chase_step40", LEDR, 10'h001);

    apply_stimulus(4'b0010, 1);
    check_output("count_hex3",  {3'b0, HEX3}, 10'h024);
    check_output("count_entry", LEDR, 10'h000);
    give_ticks(4);
    check_output("count_1", LEDR, 10'h001);
    give_ticks(4);
    check_output("count_2", LEDR, 10'h002);
    give_ticks(4);
    check_output("count_3", LEDR, 10'h003);

    apply_stimulus(4'b1000, 5);
    check_output("level_sat7", {3'b0, HEX0}, 10'h078);
    give_ticks(1);
    check_output("lvl7_tick1", LEDR, 10'h004);
    give_ticks(1);
    check_output("lvl7_tick2", LEDR, 10'h005);

    apply_stimulus(4'b0100, 9);
    check_output("level_sat0", {3'b0, HEX0}, 10'h040);
    give_ticks(7);
    check_output("lvl0_7ticks", LEDR, 10'h005);
    give_ticks(1);
    check_output("lvl0_8ticks", LEDR, 10'h006);

    apply_stimulus(4'b0010, 1);
    check_output("alt_entry", LEDR, 10'h155);
    apply_stimulus(4'b0010, 1);
    check_output("wrap_up_hex3", {3'b0, HEX3}, 10'h040);
    check_output("wrap_up_ledr", LEDR, 10'h001);
    apply_stimulus(4'b0001, 1);
    check_output("wrap_dn_hex3", {3'b0, HEX3}, 10'h030);
    check_output("wrap_dn_ledr", LEDR, 10'h155);
    apply_stimulus(4'b1000, 7);
    check_output("level_back7", {3'b0, HEX0}, 10'h078);
    give_ticks(1);
    check_output("alt_2aa", LEDR, 10'h2AA);
    give_ticks(1);
    check_output("alt_155", LEDR, 10'h155);

    apply_stimulus(4'b0011, 1);
    check_output("simul_hex3", {3'b0, HEX3}, 10'h030);
    check_output("simul_ledr", LEDR, 10'h155);

    apply_stimulus(4'b0010, 1);
    check_output("bounce_entry", LEDR, 10'h001);
    give_ticks(9);
    check_output("bounce_top", LEDR, 10'h200);
    give_ticks(1);
    check_output("bounce_rev", LEDR, 10'h100);
    give_ticks(1);
    check_output("bounce_down", LEDR, 10'h080);

    // Assert reset between clock edges and look before any rising edge.
    #3;
    reset = 1'b1;
    #2;
    check_output("async_ledr", LEDR, 10'h001);
    check_output("async_hex3", {3'b0, HEX3}, 10'h040);
    check_output("async_hex0", {3'b0, HEX0}, 10'h019);
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);
    check_output("post_reset_ledr", LEDR, 10'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
